// File: rtl/qdrc_rd_ret_if.sv
// Request, read-path and response bundle for qdrc_rd_ret.
// slave is the qdrc_rd_ret side; master is the user and read-path side.
interface qdrc_rd_ret_if #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned TAG_WIDTH  = 8
) ();

  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic                      rd_strb;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [2*DATA_WIDTH-1:0]   rd_data;
  logic                      rd_dvld;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [2*DATA_WIDTH-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]      rsp_tag;

  modport master (
    output req_valid, req_addr, req_tag, rd_data, rd_dvld, rsp_ready,
    input  req_ready, rd_strb, rd_addr, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_addr, req_tag, rd_data, rd_dvld, rsp_ready,
    output req_ready, rd_strb, rd_addr, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/qdrc_rd_ret.sv
// Read request issue and tagged return buffering ahead of the QDR read path.
// Optional QDRC_RD_RET_STATS_EN adds response count and inflight high-water outputs.
module qdrc_rd_ret #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  phy_rdy,
  qdrc_rd_ret_if.slave          bus,
  output logic [DEPTH_LOG2:0]   inflight,
  output logic                  err_orphan
`ifdef QDRC_RD_RET_STATS_EN
  ,
  output logic [31:0]           stat_rd_count,
  output logic [DEPTH_LOG2:0]   stat_max_inflight
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned RW    = 2 * DATA_WIDTH + TAG_WIDTH;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  logic                  gap_q;
  logic                  rd_strb_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  cnt_t                  inflight_q;
  logic                  err_orphan_q;

  logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];
  ptr_t                  tag_wr_q, tag_rd_q;
  cnt_t                  tag_cnt_q;

  logic [RW-1:0]         ret_mem [DEPTH];
  ptr_t                  ret_wr_q, ret_rd_q;
  cnt_t                  ret_cnt_q;

  logic                  rsp_valid_q;
  logic [RW-1:0]         rsp_word_q;

  logic                  req_ready;
  logic                  accept;
  logic                  tag_empty;
  logic                  ret_push;
  logic [RW-1:0]         ret_word;
  logic                  rsp_pop;
  logic                  out_load;
  logic                  mem_pop;
  logic                  mem_push;

  always_comb begin
    req_ready = !reset && phy_rdy && !gap_q && (inflight_q < CNT_FULL);
    accept    = bus.req_valid && req_ready;
    tag_empty = (tag_cnt_q == '0);
    ret_push  = bus.rd_dvld && !tag_empty;
    ret_word  = {bus.rd_data, tag_mem[tag_rd_q]};
    rsp_pop   = rsp_valid_q && bus.rsp_ready;
    // Output register refills from storage first; with storage empty it takes
    // the incoming word directly so an empty FIFO still has 1-cycle latency.
    out_load  = !rsp_valid_q || rsp_pop;
    mem_pop   = out_load && (ret_cnt_q != '0);
    mem_push  = ret_push && !(out_load && (ret_cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q        <= 1'b0;
      rd_strb_q    <= 1'b0;
      rd_addr_q    <= '0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      ret_wr_q     <= '0;
      ret_rd_q     <= '0;
      ret_cnt_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_word_q   <= '0;
    end else begin
      gap_q     <= accept;
      rd_strb_q <= accept;
      if (accept) rd_addr_q <= bus.req_addr;

      case ({accept, rsp_pop})
        2'b10:   inflight_q <= inflight_q + CNT_ONE;
        2'b01:   inflight_q <= inflight_q - CNT_ONE;
        default: inflight_q <= inflight_q;
      endcase

      if (bus.rd_dvld && tag_empty) err_orphan_q <= 1'b1;

      if (accept)   tag_wr_q <= tag_wr_q + PTR_ONE;
      if (ret_push) tag_rd_q <= tag_rd_q + PTR_ONE;
      case ({accept, ret_push})
        2'b10:   tag_cnt_q <= tag_cnt_q + CNT_ONE;
        2'b01:   tag_cnt_q <= tag_cnt_q - CNT_ONE;
        default: tag_cnt_q <= tag_cnt_q;
      endcase

      if (mem_push) ret_wr_q <= ret_wr_q + PTR_ONE;
      if (mem_pop)  ret_rd_q <= ret_rd_q + PTR_ONE;
      case ({mem_push, mem_pop})
        2'b10:   ret_cnt_q <= ret_cnt_q + CNT_ONE;
        2'b01:   ret_cnt_q <= ret_cnt_q - CNT_ONE;
        default: ret_cnt_q <= ret_cnt_q;
      endcase

      if (out_load) begin
        if (mem_pop) begin
          rsp_valid_q <= 1'b1;
          rsp_word_q  <= ret_mem[ret_rd_q];
        end else if (ret_push) begin
          rsp_valid_q <= 1'b1;
          rsp_word_q  <= ret_word;
        end else begin
          rsp_valid_q <= 1'b0;
        end
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (accept)   tag_mem[tag_wr_q] <= bus.req_tag;
    if (mem_push) ret_mem[ret_wr_q] <= ret_word;
  end

  always_comb begin
    bus.req_ready = req_ready;
    bus.rd_strb   = rd_strb_q;
    bus.rd_addr   = rd_addr_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_data  = rsp_word_q[RW-1:TAG_WIDTH];
    bus.rsp_tag   = rsp_word_q[TAG_WIDTH-1:0];
    inflight      = inflight_q;
    err_orphan    = err_orphan_q;
  end

`ifdef QDRC_RD_RET_STATS_EN
  logic [31:0] stat_rd_count_q;
  cnt_t        stat_max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_count_q <= '0;
      stat_max_q      <= '0;
    end else begin
      if (rsp_pop) stat_rd_count_q <= stat_rd_count_q + 32'd1;
      if (inflight_q > stat_max_q) stat_max_q <= inflight_q;
    end
  end

  always_comb begin
    stat_rd_count     = stat_rd_count_q;
    stat_max_inflight = stat_max_q;
  end
`endif

endmodule

// File: tb/tb_qdrc_rd_ret.sv
// Directed bench for qdrc_rd_ret: cycle model of handshake/credit state plus a
// response scoreboard filled at request acceptance, and a fixed-latency read path.
module tb_qdrc_rd_ret;

  localparam int unsigned DW = 36;
  localparam int unsigned AW = 21;
  localparam int unsigned TW = 8;
  localparam int unsigned DL = 4;
  localparam int          RD_LAT = 11;  // strobe cycle to rd_dvld cycle

  logic          clk = 1'b0;
  logic          reset;
  logic          phy_rdy;
  logic [DL:0]   inflight;
  logic          err_orphan;
`ifdef QDRC_RD_RET_STATS_EN
  logic [31:0]   stat_rd_count;
  logic [DL:0]   stat_max_inflight;
`endif

  qdrc_rd_ret_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  qdrc_rd_ret #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TAG_WIDTH (TW),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .phy_rdy   (phy_rdy),
    .bus       (bus),
    .inflight  (inflight),
    .err_orphan(err_orphan)
`ifdef QDRC_RD_RET_STATS_EN
    ,
    .stat_rd_count    (stat_rd_count),
    .stat_max_inflight(stat_max_inflight)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_hs  = 0;

  // Bench model state
  logic          m_gap, m_strb, m_orphan, last_acc;
  logic [AW-1:0] m_addr;
  int            m_inflight, m_tags, m_avail, acc_cyc;
  logic          orphan_req;

  logic [2*DW+TW-1:0] exp_q [$];
  int                 due_q [$];
  logic [AW-1:0]      paddr_q [$];

  function automatic logic [2*DW-1:0] data_for(input logic [AW-1:0] a);
    return {a, 15'h2B3C, ~a, 15'h0F1E};
  endfunction

  task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_gap = 0; m_strb = 0; m_orphan = 0; m_addr = '0; last_acc = 0;
    m_inflight = 0; m_tags = 0; m_avail = 0;
    exp_q.delete(); due_q.delete(); paddr_q.delete();
  endtask

  task automatic tick();
    logic hs, acc, exp_ready;
    logic [2*DW+TW-1:0] e;
    int tags_before;
    @(negedge clk);
    hs        = bus.rsp_valid && bus.rsp_ready;
    exp_ready = phy_rdy && !m_gap && (m_inflight < 16);
    chk("req_ready", 96'(bus.req_ready), 96'(exp_ready));
    chk("rd_strb", 96'(bus.rd_strb), 96'(m_strb));
    if (m_strb) chk("rd_addr", 96'(bus.rd_addr), 96'(m_addr));
    chk("inflight", 96'(inflight), 96'(m_inflight));
    chk("err_orphan", 96'(err_orphan), 96'(m_orphan));
    chk("rsp_valid", 96'(bus.rsp_valid), 96'(m_avail != 0));
    if (hs) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL rsp_unexpected: observed tag=%0h expected no response", bus.rsp_tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_order", 96'({bus.rsp_data, bus.rsp_tag}), 96'(e));
        n_hs++;
      end
    end
    if (bus.rd_strb) begin
      due_q.push_back(cyc + RD_LAT);
      paddr_q.push_back(bus.rd_addr);
    end
    acc         = bus.req_valid && exp_ready;
    tags_before = m_tags;
    if (acc) begin
      exp_q.push_back({data_for(bus.req_addr), bus.req_tag});
      m_tags++;
      acc_cyc = cyc;
    end
    if (bus.rd_dvld) begin
      if (tags_before > 0) begin
        m_tags--;
        m_avail++;
      end else begin
        m_orphan = 1;
      end
    end
    if (hs && m_avail > 0) m_avail--;
    m_inflight = m_inflight + int'(acc) - int'(hs);
    m_strb     = acc;
    m_gap      = acc;
    if (acc) m_addr = bus.req_addr;
    last_acc = acc;
    @(posedge clk);
    cyc++;
    #1;
    bus.rd_dvld = 0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      bus.rd_data = data_for(paddr_q.pop_front());
      bus.rd_dvld = 1;
    end
    if (orphan_req) begin
      bus.rd_data = {$urandom(), $urandom(), 8'h3C};
      bus.rd_dvld = 1;
      orphan_req  = 0;
    end
  endtask

  task automatic do_reset();
    reset         = 1;
    bus.req_valid = 0;
    bus.rd_dvld   = 0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_req_ready"}, 96'(bus.req_ready), 96'(0));
    chk({pfx, "_rd_strb"}, 96'(bus.rd_strb), 96'(0));
    chk({pfx, "_rd_addr"}, 96'(bus.rd_addr), 96'(0));
    chk({pfx, "_rsp_valid"}, 96'(bus.rsp_valid), 96'(0));
    chk({pfx, "_rsp_data"}, 96'(bus.rsp_data), 96'(0));
    chk({pfx, "_rsp_tag"}, 96'(bus.rsp_tag), 96'(0));
    chk({pfx, "_inflight"}, 96'(inflight), 96'(0));
    chk({pfx, "_err_orphan"}, 96'(err_orphan), 96'(0));
  endtask

  task automatic send(input logic [TW-1:0] tag, input logic [AW-1:0] addr);
    int g = 0;
    bus.req_valid = 1;
    bus.req_tag   = tag;
    bus.req_addr  = addr;
    do begin
      tick();
      g++;
    end while (!last_acc && g < 60);
    total++;
    assert (last_acc) else begin
      bad++;
      $error("FAIL send_timeout: observed no accept for tag %0h expected accept", tag);
    end
    bus.req_valid = 0;
  endtask

  task automatic drain(input int bound);
    int g = 0;
    while ((exp_q.size() != 0 || due_q.size() != 0) && g < bound) begin
      tick();
      g++;
    end
    chk("drain_left", 96'(exp_q.size()), 96'(0));
  endtask

  int acc_c [4];
  int n0;

  initial begin
    phy_rdy       = 0;
    bus.req_valid = 0;
    bus.req_addr  = '0;
    bus.req_tag   = '0;
    bus.rd_data   = '0;
    bus.rd_dvld   = 0;
    bus.rsp_ready = 1;
    orphan_req    = 0;
    acc_cyc       = 0;
    do_reset();
    check_reset_values("reset");

    // phy_rdy low blocks acceptance; raising it accepts in the same cycle
    bus.req_valid = 1;
    bus.req_tag   = 8'h5A;
    bus.req_addr  = 21'h00123;
    repeat (3) tick();
    phy_rdy = 1;
    #1;
    chk("ready_on_phy_rdy", 96'(bus.req_ready), 96'(1));
    tick();
    bus.req_valid = 0;
    chk("single_accept", 96'(last_acc), 96'(bus.req_ready === 1'b0));
    n0 = 0;
    while (!bus.rsp_valid && n0 < 40) begin
      tick();
      n0++;
    end
    chk("single_latency", 96'(cyc - acc_cyc), 96'(13));
    chk("single_tag", 96'(bus.rsp_tag), 96'(8'h5A));
    chk("single_data", 96'(bus.rsp_data), 96'(data_for(21'h00123)));
    tick();
    chk("single_inflight_zero", 96'(inflight), 96'(0));

    // back-to-back requests: accepts exactly 2 cycles apart, in-order returns
    for (int i = 0; i < 4; i++) begin
      send(TW'(i + 1), AW'(21'h0A000 + i * 3));
      acc_c[i] = acc_cyc;
    end
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 96'(acc_c[i] - acc_c[i-1]), 96'(2));
    drain(60);

    // credit exhaustion with the consumer stalled
    bus.rsp_ready = 0;
    for (int i = 0; i < 16; i++) send(TW'(8'h80 + i), AW'(21'h1F000 + i * 7));
    repeat (20) tick();
    chk("full_inflight", 96'(inflight), 96'(16));
    bus.req_valid = 1;
    bus.req_tag   = 8'hEE;
    bus.req_addr  = 21'h1ABCD;
    #1;
    chk("full_req_ready", 96'(bus.req_ready), 96'(0));
    chk("full_head_tag", 96'(bus.rsp_tag), 96'(8'h80));
    repeat (3) tick();
    chk("full_head_hold", 96'(bus.rsp_tag), 96'(8'h80));
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    tick();
    chk("credit_return_ready", 96'(bus.req_ready), 96'(1));
    drain(60);
    chk("full_drain_inflight", 96'(inflight), 96'(0));

    // orphan data with nothing outstanding
    orphan_req = 1;
    repeat (3) tick();
    chk("orphan_set", 96'(err_orphan), 96'(1));
    chk("orphan_no_rsp", 96'(bus.rsp_valid), 96'(0));
    repeat (5) tick();
    chk("orphan_sticky", 96'(err_orphan), 96'(1));

    // reset with reads outstanding, then fresh traffic
    for (int i = 0; i < 3; i++) send(TW'(8'h40 + i), AW'(21'h05550 + i));
    tick();
    phy_rdy = 0;
    do_reset();
    check_reset_values("midreset");
    repeat (15) tick();
    phy_rdy = 1;
    send(8'hC1, 21'h1FFFF);
    send(8'hC2, 21'h00000);
    drain(60);
    chk("post_reset_inflight", 96'(inflight), 96'(0));

`ifdef QDRC_RD_RET_STATS_EN
    chk("stat_rd_count", 96'(stat_rd_count), 96'(2));
    chk("stat_max_inflight", 96'(stat_max_inflight), 96'(2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
